gmii_tx_framer: RTL and testbench
=================================

// Module: gmii_tx_framer
// PURPOSE
//  Transmit MAC framer sitting directly upstream of the PCS/PMA PHY top: drives its gmii_txd/gmii_tx_en/gmii_tx_er.
//  Accepts a byte stream (valid/ready/last) and emits a full 802.3 frame:
//  - preamble, SFD, payload, optional pad, CRC-32 FCS;
//  - then enforces the inter-frame gap.
//  Runs entirely in the gmii_tx_clk (userclk2, 125 MHz) domain.
// PARAMETERS
//  IFG_BYTES   12  idle cycles (tx_en=0) forced after each frame; legal range 1..255
//  MIN_PAYLOAD 60  minimum bytes before FCS (pad target); legal range 1..255
// PORTS
//  gmii_tx_clk  in   1  sole clock; all logic on rising edge
//  reset        in   1  asynchronous, active-high; clears all state
//  s_tdata      in   8  payload byte (destination MAC first)
//  s_tvalid     in   1  s_tdata valid
//  s_tlast      in   1  marks final payload byte
//  s_tready     out  1  byte accepted on the cycle where s_tvalid & s_tready
//  gmii_txd     out  8  to PHY gmii_txd
//  gmii_tx_en   out  1  to PHY gmii_tx_en
//  gmii_tx_er   out  1  to PHY gmii_tx_er
//  busy         out  1  high from frame start until IFG completes
//  underrun     out  1  one-cycle pulse when a frame is aborted for underrun
// BEHAVIOUR
//  Reset values: gmii_txd=0, gmii_tx_en=0, gmii_tx_er=0, s_tready=0, busy=0, underrun=0; state=IDLE.
//  All GMII outputs are registered.
//  FSM states: IDLE, PRE, SFD, DATA, PAD, FCS, IFG, DRAIN.
//  IDLE:
//  - s_tvalid=1 -> PRE; the next cycle shows gmii_tx_en=1, gmii_txd=0x55.
//  - busy rises in that same cycle.
//  PRE: 7 cycles of 0x55, then SFD.
//  SFD: 1 cycle of 0xD5, then DATA.
//  - s_tready is high during the SFD cycle and in DATA, so the first payload byte is on gmii_txd the cycle after 0xD5.
//  - No gap between bytes.
//  DATA: each accepted byte appears on gmii_txd 1 cycle later; 11-bit byte counter increments (saturates at 2047).
//  DATA exit on accepted byte with s_tlast=1:
//  - count < MIN_PAYLOAD -> PAD;
//  - otherwise -> FCS.
//  - s_tready drops the cycle after the tlast accept.
//  PAD: emits 0x00 until count == MIN_PAYLOAD, then FCS.
//  CRC: IEEE 802.3 CRC-32, reflected, poly 0xEDB88320, init 0xFFFFFFFF.
//  - Covers payload+pad only, not preamble/SFD.
//  - Updated 1 byte/cycle.
//  FCS: 4 cycles of ~crc, LSB byte first. Then IFG: tx_en=0 for exactly IFG_BYTES cycles, then IDLE.
//  - busy falls on entry to IDLE.
//  - s_tvalid held high across IFG is not accepted until IDLE.
//  Underrun: s_tvalid=0 in DATA before tlast. That cycle:
//  - gmii_tx_en=1, gmii_tx_er=1, gmii_txd=0x00;
//  - underrun pulses.
//  - Next state is DRAIN: tx_en=0, s_tready=1, bytes discarded up to and including tlast, then IFG.
//  Underrun is never declared in PRE/SFD/PAD/FCS.
//  Frames longer than 2047 bytes are transmitted unmodified; only the counter saturates.
//  Async reset mid-frame: outputs go to reset values immediately; partial frame is truncated (no FCS); state=IDLE.
// CONFIGURATION
//  `GMII_TX_PAD_EN` defined:
//  - PAD state is present and short frames are zero-padded to MIN_PAYLOAD before FCS.
//  `GMII_TX_PAD_EN` undefined:
//  - PAD is removed and DATA always goes to FCS after tlast.
//  - Short frames are sent unpadded; MIN_PAYLOAD is ignored.
// TESTING
//  1 Reset: assert reset mid-preamble -> tx_en/tx_er/txd=0 same cycle; after release, idle with s_tready=0.
//  2 Pad off, payload ASCII "123456789" (9 bytes):
//    - GMII shows 7x55, D5, 31..39, then 26 39 F4 CB (CRC 0xCBF43926 complemented to FCS bytes);
//    - then exactly 12 tx_en=0 cycles.
//  3 Pad on, 14-byte payload:
//    - 46 bytes of 0x00 follow the payload (60 total), then 4 FCS bytes matching the software CRC;
//    - tx_en high for 72 consecutive cycles.
//  4 Back-to-back: two 64-byte frames with s_tvalid held high -> second 0x55 starts exactly IFG_BYTES cycles after the first frame's last FCS byte.
//  5 Underrun: drop s_tvalid at payload byte 20 of 100:
//    - one cycle with tx_en=1, tx_er=1; underrun pulses;
//    - the remaining 80 bytes are drained with tx_en=0; IFG follows.
//  6 Backpressure: s_tvalid held high at IDLE -> s_tready first high in the 0xD5 cycle; payload continuous with no bubbles.

Source files
------------

// File: rtl/gmii_tx_framer.sv
// gmii_tx_framer: byte stream to GMII frame (7x55, D5, payload, zero pad under `GMII_TX_PAD_EN, CRC-32 FCS) plus forced IFG.
// Latency: first 0x55 one cycle after s_tvalid in IDLE; each accepted byte reaches gmii_txd one cycle later.
// Backpressure: s_tready only in the SFD-display cycle onwards (DATA) and DRAIN; an empty cycle mid-payload aborts the frame.
module gmii_tx_framer #(
   parameter int IFG_BYTES   = 12,
   parameter int MIN_PAYLOAD = 60
) (
   input  logic       gmii_tx_clk,
   input  logic       reset,
   input  logic [7:0] s_tdata,
   input  logic       s_tvalid,
   input  logic       s_tlast,
   output logic       s_tready,
   output logic [7:0] gmii_txd,
   output logic       gmii_tx_en,
   output logic       gmii_tx_er,
   output logic       busy,
   output logic       underrun
);

   // State names the byte being generated this cycle; it is shown on GMII next cycle.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PRE   = 3'd1,
      SFD   = 3'd2,
      DATA  = 3'd3,
`ifdef GMII_TX_PAD_EN
      PAD   = 3'd4,
`endif
      FCS   = 3'd5,
      IFG   = 3'd6,
      DRAIN = 3'd7
   } state_t;

   if (IFG_BYTES < 1 || IFG_BYTES > 255 || MIN_PAYLOAD < 1 || MIN_PAYLOAD > 255) begin : g_bad_params
      $error("gmii_tx_framer: IFG_BYTES and MIN_PAYLOAD must lie in 1..255");
   end

   state_t      state, next_state;
   logic [10:0] byte_cnt;
   logic [10:0] cnt_inc;
   logic [7:0]  sub_cnt;
   logic [31:0] crc;
   logic [31:0] fcs_word;
   logic        accept;
   logic [7:0]  txd_d;
   logic        tx_en_d;
   logic        tx_er_d;
   logic        underrun_d;

   function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'd0, d};
      for (int i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
      return r;
   endfunction

   assign s_tready = (state == DATA) || (state == DRAIN);
   assign busy     = (state != IDLE);
   assign accept   = s_tvalid && s_tready;
   assign cnt_inc  = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;
   assign fcs_word = ~crc;

   always_ff @(posedge gmii_tx_clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:  if (s_tvalid) next_state = PRE;
         PRE:   if (sub_cnt == 8'd5) next_state = SFD;
         SFD:   next_state = DATA;
         DATA: begin
            if (!s_tvalid)
               next_state = DRAIN;
            else if (s_tlast)
`ifdef GMII_TX_PAD_EN
               next_state = (cnt_inc < 11'(MIN_PAYLOAD)) ? PAD : FCS;
`else
               next_state = FCS;
`endif
         end
`ifdef GMII_TX_PAD_EN
         PAD:   if (cnt_inc >= 11'(MIN_PAYLOAD)) next_state = FCS;
`endif
         FCS:   if (sub_cnt == 8'd3) next_state = IFG;
         IFG:   if (sub_cnt == 8'(IFG_BYTES - 1)) next_state = IDLE;
         DRAIN: if (accept && s_tlast) next_state = IFG;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      txd_d      = 8'h00;
      tx_en_d    = 1'b0;
      tx_er_d    = 1'b0;
      underrun_d = 1'b0;
      case (state)
         IDLE: begin
            if (s_tvalid) begin
               tx_en_d = 1'b1;
               txd_d   = 8'h55;
            end
         end
         PRE: begin
            tx_en_d = 1'b1;
            txd_d   = 8'h55;
         end
         SFD: begin
            tx_en_d = 1'b1;
            txd_d   = 8'hD5;
         end
         DATA: begin
            tx_en_d = 1'b1;
            if (s_tvalid) begin
               txd_d = s_tdata;
            end else begin
               tx_er_d    = 1'b1;
               underrun_d = 1'b1;
            end
         end
`ifdef GMII_TX_PAD_EN
         PAD:     tx_en_d = 1'b1;
`endif
         FCS: begin
            tx_en_d = 1'b1;
            txd_d   = fcs_word[{sub_cnt[1:0], 3'b000} +: 8];
         end
         default: ;
      endcase
   end

   always_ff @(posedge gmii_tx_clk or posedge reset) begin
      if (reset) begin
         gmii_txd   <= 8'h00;
         gmii_tx_en <= 1'b0;
         gmii_tx_er <= 1'b0;
         underrun   <= 1'b0;
         byte_cnt   <= 11'd0;
         sub_cnt    <= 8'd0;
         crc        <= 32'hFFFF_FFFF;
      end else begin
         gmii_txd   <= txd_d;
         gmii_tx_en <= tx_en_d;
         gmii_tx_er <= tx_er_d;
         underrun   <= underrun_d;
         // sub_cnt times PRE, FCS and IFG; it restarts on every state change
         sub_cnt    <= (next_state != state) ? 8'd0 : sub_cnt + 8'd1;
         if (state == IDLE) begin
            byte_cnt <= 11'd0;
            crc      <= 32'hFFFF_FFFF;
         end else if (state == DATA && accept) begin
            byte_cnt <= cnt_inc;
            crc      <= crc32_byte(crc, s_tdata);
         end
`ifdef GMII_TX_PAD_EN
         else if (state == PAD) begin
            byte_cnt <= cnt_inc;
            crc      <= crc32_byte(crc, 8'h00);
         end
`endif
      end
   end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Bench for gmii_tx_framer: random payloads driven over valid/ready, GMII frames captured by a monitor
// and compared against a frame model built from preamble/SFD/pad/bit-serial CRC rules.
`timescale 1ns/1ps
module tb_gmii_tx_framer;
   localparam int IFG  = 12;
   localparam int MINP = 60;
`ifdef GMII_TX_PAD_EN
   localparam bit PAD_ON = 1'b1;
`else
   localparam bit PAD_ON = 1'b0;
`endif

   logic       gmii_tx_clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] s_tdata = 8'h00;
   logic       s_tvalid = 1'b0;
   logic       s_tlast = 1'b0;
   logic       s_tready;
   logic [7:0] gmii_txd;
   logic       gmii_tx_en;
   logic       gmii_tx_er;
   logic       busy;
   logic       underrun;

   int n_checks = 0;
   int n_pass = 0;
   int drv_timeouts = 0;

   gmii_tx_framer #(.IFG_BYTES(IFG), .MIN_PAYLOAD(MINP)) dut (
      .gmii_tx_clk(gmii_tx_clk),
      .reset      (reset),
      .s_tdata    (s_tdata),
      .s_tvalid   (s_tvalid),
      .s_tlast    (s_tlast),
      .s_tready   (s_tready),
      .gmii_txd   (gmii_txd),
      .gmii_tx_en (gmii_tx_en),
      .gmii_tx_er (gmii_tx_er),
      .busy       (busy),
      .underrun   (underrun)
   );

   always #4 gmii_tx_clk = ~gmii_tx_clk;

   // Monitor: frames are runs of tx_en=1; gap = idle cycles preceding each frame.
   byte unsigned rx_bytes[$];
   int rx_len[$];
   int rx_gap[$];
   int rx_rdy_pos[$];
   int cur_len = 0;
   int idle_run = 0;
   int rdy_pos = -1;
   int er_cycles = 0;
   int und_pulses = 0;
   int er_und_ok = 0;

   always @(negedge gmii_tx_clk) begin
      if (gmii_tx_en) begin
         if (cur_len == 0) begin
            rx_gap.push_back(idle_run);
            rdy_pos = -1;
         end
         if (s_tready && rdy_pos < 0) rdy_pos = cur_len;
         rx_bytes.push_back(gmii_txd);
         cur_len++;
      end else begin
         if (cur_len != 0) begin
            rx_len.push_back(cur_len);
            rx_rdy_pos.push_back(rdy_pos);
            cur_len = 0;
            idle_run = 0;
         end
         idle_run++;
      end
      if (gmii_tx_er) er_cycles++;
      if (underrun) und_pulses++;
      if (gmii_tx_en && gmii_tx_er && underrun && gmii_txd == 8'h00) er_und_ok++;
   end

   task automatic model_frame(input byte unsigned p[$], output byte unsigned e[$]);
      byte unsigned body[$];
      logic [31:0] c;
      bit fb;
      body = p;
      if (PAD_ON) while (body.size() < MINP) body.push_back(8'h00);
      c = 32'hFFFF_FFFF;
      foreach (body[i])
         for (int b = 0; b < 8; b++) begin
            fb = c[0] ^ body[i][b];
            c = c >> 1;
            if (fb) c = c ^ 32'hEDB8_8320;
         end
      c = ~c;
      e = {};
      repeat (7) e.push_back(8'h55);
      e.push_back(8'hD5);
      foreach (body[i]) e.push_back(body[i]);
      for (int k = 0; k < 4; k++) e.push_back(c[8*k +: 8]);
   endtask

   task automatic rand_payload(input int n, output byte unsigned p[$]);
      p = {};
      for (int k = 0; k < n; k++) p.push_back(8'($urandom_range(0, 255)));
   endtask

   task automatic get_frame(input int idx, output byte unsigned f[$]);
      int s = 0;
      f = {};
      if (idx >= rx_len.size()) return;
      for (int k = 0; k < idx; k++) s += rx_len[k];
      for (int k = 0; k < rx_len[idx]; k++) f.push_back(rx_bytes[s+k]);
   endtask

   function automatic int count_diff(input byte unsigned a[$], input byte unsigned b[$]);
      int d = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
      for (int k = 0; k < a.size() && k < b.size(); k++)
         if (a[k] !== b[k]) d++;
      return d;
   endfunction

   // Drives one payload; stall_at drops s_tvalid for one cycle before that byte.
   task automatic send_frame(input byte unsigned p[$], input int stall_at, input bit hold, output int bubbles);
      bit rdy;
      int guard;
      bubbles = 0;
      foreach (p[i]) begin
         if (i == stall_at) begin
            s_tvalid = 1'b0;
            @(posedge gmii_tx_clk); #1;
         end
         s_tvalid = 1'b1;
         s_tdata  = p[i];
         s_tlast  = (i == p.size() - 1);
         guard = 0;
         do begin
            @(negedge gmii_tx_clk);
            rdy = s_tready;
            @(posedge gmii_tx_clk); #1;
            guard++;
            if (i > 0 && i != stall_at && !rdy) bubbles++;
         end while (!rdy && guard < 2000);
         if (!rdy) drv_timeouts++;
      end
      if (!hold) begin
         s_tvalid = 1'b0;
         s_tlast  = 1'b0;
      end
   endtask

   task automatic wait_frames(input int target);
      int g = 0;
      while (rx_len.size() < target && g < 5000) begin
         @(posedge gmii_tx_clk);
         g++;
      end
      #1;
   endtask

   task automatic wait_idle();
      int g = 0;
      while ((busy || gmii_tx_en) && g < 5000) begin
         @(posedge gmii_tx_clk);
         g++;
      end
      repeat (2) @(posedge gmii_tx_clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge gmii_tx_clk);
      #1;
      n_checks++;
      if ({gmii_txd, gmii_tx_en, gmii_tx_er, s_tready, busy, underrun} !== 13'd0)
         $display("FAIL reset_values: got %b want all zero", {gmii_txd, gmii_tx_en, gmii_tx_er, s_tready, busy, underrun});
      else n_pass++;
      @(negedge gmii_tx_clk) reset = 1'b0;
      @(posedge gmii_tx_clk); #1;
      s_tvalid = 1'b1;
      s_tdata  = 8'hAA;
      s_tlast  = 1'b0;
      repeat (3) @(posedge gmii_tx_clk);
      #1;
      n_checks++;
      if ({gmii_tx_en, gmii_txd, busy} !== {1'b1, 8'h55, 1'b1})
         $display("FAIL preamble_before_reset: got en=%b txd=%h busy=%b want 1 55 1", gmii_tx_en, gmii_txd, busy);
      else n_pass++;
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if ({gmii_txd, gmii_tx_en, gmii_tx_er} !== 10'd0)
         $display("FAIL async_reset_outputs: got txd=%h en=%b er=%b want 0 0 0", gmii_txd, gmii_tx_en, gmii_tx_er);
      else n_pass++;
      s_tvalid = 1'b0;
      repeat (2) @(posedge gmii_tx_clk);
      @(negedge gmii_tx_clk) reset = 1'b0;
      repeat (3) @(posedge gmii_tx_clk);
      #1;
      n_checks++;
      if ({s_tready, gmii_tx_en, busy, underrun} !== 4'd0)
         $display("FAIL idle_after_reset: got rdy=%b en=%b busy=%b und=%b want 0000", s_tready, gmii_tx_en, busy, underrun);
      else n_pass++;
   endtask

   task automatic test_known_vector();
      byte unsigned p[$], p2[$], e[$], f[$];
      int base = rx_len.size();
      int bub1, bub2;
      p = {};
      for (int k = 0; k < 9; k++) p.push_back(8'(8'h31 + k));
      rand_payload(20, p2);
      send_frame(p, -1, 1'b1, bub1);
      send_frame(p2, -1, 1'b0, bub2);
      wait_frames(base + 2);
      n_checks++;
      if (rx_len.size() < base + 2) $display("FAIL kv_frame_count: got %0d want %0d", rx_len.size() - base, 2);
      else n_pass++;
      model_frame(p, e);
      get_frame(base, f);
      n_checks++;
      if (count_diff(f, e) !== 0) $display("FAIL kv_frame_bytes: got %0d differing bytes want 0", count_diff(f, e));
      else n_pass++;
`ifndef GMII_TX_PAD_EN
      n_checks++;
      if (f.size() < 21 || {f[20], f[19], f[18], f[17]} !== 32'hCBF4_3926)
         $display("FAIL kv_fcs_literal: got %0d bytes, want FCS 26 39 F4 CB at 17..20", f.size());
      else n_pass++;
`endif
      n_checks++;
      if (rx_gap.size() <= base + 1 || rx_gap[base+1] !== IFG)
         $display("FAIL kv_ifg: got %0d want %0d", (rx_gap.size() > base + 1) ? rx_gap[base+1] : -1, IFG);
      else n_pass++;
      model_frame(p2, e);
      get_frame(base + 1, f);
      n_checks++;
      if (count_diff(f, e) !== 0) $display("FAIL kv_second_frame: got %0d differing bytes want 0", count_diff(f, e));
      else n_pass++;
      wait_idle();
   endtask

   task automatic test_pad();
      byte unsigned p[$], e[$], f[$];
      int base = rx_len.size();
      int bub;
      int want_len = PAD_ON ? 8 + MINP + 4 : 8 + 14 + 4;
      rand_payload(14, p);
      send_frame(p, -1, 1'b0, bub);
      wait_frames(base + 1);
      n_checks++;
      if (rx_len.size() <= base || rx_len[base] !== want_len)
         $display("FAIL pad_tx_en_run: got %0d want %0d", (rx_len.size() > base) ? rx_len[base] : -1, want_len);
      else n_pass++;
      model_frame(p, e);
      get_frame(base, f);
      n_checks++;
      if (count_diff(f, e) !== 0) $display("FAIL pad_frame_bytes: got %0d differing bytes want 0", count_diff(f, e));
      else n_pass++;
      wait_idle();
   endtask

   task automatic test_back_to_back();
      byte unsigned p1[$], p2[$], e[$], f[$];
      int base = rx_len.size();
      int bub1, bub2;
      rand_payload(64, p1);
      rand_payload(64, p2);
      send_frame(p1, -1, 1'b1, bub1);
      send_frame(p2, -1, 1'b0, bub2);
      wait_frames(base + 2);
      model_frame(p1, e);
      get_frame(base, f);
      n_checks++;
      if (count_diff(f, e) !== 0) $display("FAIL b2b_frame1: got %0d differing bytes want 0", count_diff(f, e));
      else n_pass++;
      model_frame(p2, e);
      get_frame(base + 1, f);
      n_checks++;
      if (count_diff(f, e) !== 0) $display("FAIL b2b_frame2: got %0d differing bytes want 0", count_diff(f, e));
      else n_pass++;
      n_checks++;
      if (rx_gap.size() <= base + 1 || rx_gap[base+1] !== IFG)
         $display("FAIL b2b_ifg: got %0d want %0d", (rx_gap.size() > base + 1) ? rx_gap[base+1] : -1, IFG);
      else n_pass++;
      n_checks++;
      if (bub1 + bub2 !== 0) $display("FAIL b2b_bubbles: got %0d want 0", bub1 + bub2);
      else n_pass++;
      wait_idle();
   endtask

   task automatic test_underrun();
      byte unsigned p[$], p2[$], e[$], f[$];
      int base = rx_len.size();
      int er0 = er_cycles, und0 = und_pulses, ok0 = er_und_ok;
      int bub;
      rand_payload(100, p);
      rand_payload(30, p2);
      send_frame(p, 20, 1'b1, bub);
      send_frame(p2, -1, 1'b0, bub);
      wait_frames(base + 2);
      e = {};
      repeat (7) e.push_back(8'h55);
      e.push_back(8'hD5);
      for (int k = 0; k < 20; k++) e.push_back(p[k]);
      e.push_back(8'h00);
      get_frame(base, f);
      n_checks++;
      if (count_diff(f, e) !== 0) $display("FAIL ur_truncated_frame: got %0d bytes (%0d differ) want 29", f.size(), count_diff(f, e));
      else n_pass++;
      n_checks++;
      if ({er_cycles - er0, und_pulses - und0, er_und_ok - ok0} !== {32'd1, 32'd1, 32'd1})
         $display("FAIL ur_er_pulse: got er=%0d und=%0d aligned=%0d want 1 1 1", er_cycles - er0, und_pulses - und0, er_und_ok - ok0);
      else n_pass++;
      n_checks++;
      if (rx_gap.size() <= base + 1 || rx_gap[base+1] < IFG + 79 || rx_gap[base+1] > IFG + 81)
         $display("FAIL ur_drain_gap: got %0d want about %0d", (rx_gap.size() > base + 1) ? rx_gap[base+1] : -1, IFG + 80);
      else n_pass++;
      model_frame(p2, e);
      get_frame(base + 1, f);
      n_checks++;
      if (count_diff(f, e) !== 0) $display("FAIL ur_next_frame: got %0d differing bytes want 0", count_diff(f, e));
      else n_pass++;
      wait_idle();
   endtask

   task automatic test_backpressure();
      byte unsigned p[$], e[$], f[$];
      int base = rx_len.size();
      int bub;
      rand_payload(40, p);
      send_frame(p, -1, 1'b0, bub);
      wait_frames(base + 1);
      n_checks++;
      if (rx_rdy_pos.size() <= base || rx_rdy_pos[base] !== 7)
         $display("FAIL bp_first_ready: got pos %0d want 7 (D5 cycle)", (rx_rdy_pos.size() > base) ? rx_rdy_pos[base] : -1);
      else n_pass++;
      n_checks++;
      if (bub !== 0) $display("FAIL bp_bubbles: got %0d want 0", bub);
      else n_pass++;
      model_frame(p, e);
      get_frame(base, f);
      n_checks++;
      if (count_diff(f, e) !== 0) $display("FAIL bp_frame_bytes: got %0d differing bytes want 0", count_diff(f, e));
      else n_pass++;
      wait_idle();
   endtask

   task automatic test_random();
      byte unsigned p[$], e[$], f[$];
      byte unsigned sent[$];
      int lens[$];
      int base = rx_len.size();
      int und0 = und_pulses;
      int bub;
      int off = 0;
      for (int n = 0; n < 6; n++) begin
         rand_payload($urandom_range(1, 120), p);
         lens.push_back(p.size());
         foreach (p[i]) sent.push_back(p[i]);
         send_frame(p, -1, (n != 5) && ($urandom_range(0, 1) == 1), bub);
         if (!s_tvalid) repeat ($urandom_range(0, 20)) @(posedge gmii_tx_clk);
         #1;
      end
      wait_frames(base + 6);
      for (int n = 0; n < 6; n++) begin
         p = {};
         for (int k = 0; k < lens[n]; k++) p.push_back(sent[off+k]);
         off += lens[n];
         model_frame(p, e);
         get_frame(base + n, f);
         n_checks++;
         if (count_diff(f, e) !== 0) $display("FAIL rnd_frame%0d: got %0d differing bytes want 0", n, count_diff(f, e));
         else n_pass++;
         n_checks++;
         if (rx_gap.size() <= base + n || rx_gap[base+n] < IFG)
            $display("FAIL rnd_gap%0d: got %0d want >= %0d", n, (rx_gap.size() > base + n) ? rx_gap[base+n] : -1, IFG);
         else n_pass++;
      end
      n_checks++;
      if (und_pulses - und0 !== 0) $display("FAIL rnd_no_underrun: got %0d want 0", und_pulses - und0);
      else n_pass++;
      n_checks++;
      if (drv_timeouts !== 0) $display("FAIL driver_timeouts: got %0d want 0", drv_timeouts);
      else n_pass++;
      wait_idle();
   endtask

   initial begin
      test_reset();
      test_known_vector();
      test_pad();
      test_back_to_back();
      test_underrun();
      test_backpressure();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
